uart_rx: RTL and testbench

- Serial receiver; the receive end of the team's UART link, paired with the existing transmitter.
- Recovers N-bit frames (start bit, N data bits MSB first, one stop bit) from rx_i using 16x oversampling driven by tick_i.
- Presents each received word on a valid/read handshake; flags framing errors and overruns.
- Sits between the pad and the CRC/packet logic, in the same clock domain as the transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and oversampling constants
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 16x oversampling: tick 7 is mid start bit, tick 15 closes each bit period
    localparam logic [3:0] OSR_MID  = 4'd7;
    localparam logic [3:0] OSR_LAST = 4'd15;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input, control and read-handshake signals of the receiver
interface uart_rx_if #(parameter int N = 8);
    logic         rx_i;
    logic         tick_i;
    logic         rx_en_i;
    logic         data_re_i;
    logic [N-1:0] data_o;
    logic         data_valid_o;
    logic         frame_err_o;
    logic         overrun_o;
    logic         busy_o;

    modport master (
        input  rx_i, tick_i, rx_en_i, data_re_i,
        output data_o, data_valid_o, frame_err_o, overrun_o, busy_o
    );

    modport slave (
        output rx_i, tick_i, rx_en_i, data_re_i,
        input  data_o, data_valid_o, frame_err_o, overrun_o, busy_o
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop line synchronizer with falling-edge detect
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle line is high, so reset to 1 to avoid a spurious start edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with valid/read handshake
module uart_rx
    import uart_pkg::*;
#(
    parameter int N = 8
) (
    input logic       clk_i,
    input logic       rst_i,
    uart_rx_if.master bus
);
    localparam int BW = $clog2(N + 1);

    logic rx_s;
    logic fall;

    uart_state_t  state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [N-1:0] shift_q, shift_d;
    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ferr_q, ferr_d;
    logic         ovr_q, ovr_d;

    uart_rx_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (bus.rx_i),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q & ~bus.data_re_i;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall && bus.rx_en_i) begin
                    state_d = ST_START;
                    cnt_d   = 4'd0;
                end
            end
            ST_START: begin
                if (bus.tick_i) begin
                    if (cnt_q == OSR_MID) begin
                        cnt_d    = 4'd0;
                        bitcnt_d = '0;
                        state_d  = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.tick_i) begin
                    if (cnt_q == OSR_LAST) begin
                        shift_d  = {shift_q[N-2:0], rx_s};
                        cnt_d    = 4'd0;
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_d == BW'(N)) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.tick_i) begin
                    if (cnt_q == OSR_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                        // A read on the load cycle frees the slot, so the new word wins.
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || bus.data_re_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.overrun_o    = ovr_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic clk;
    logic rst;
    logic re_main;
    logic re_tick;
    logic arm_re;
    logic re_fired;

    int total;
    int bad;
    int ferr_cnt;
    int ovr_cnt;
    int exp_ferr;
    int exp_ovr;

    logic [7:0] mdl_data;
    logic       mdl_valid;

    uart_rx_if #(.N(8)) bus ();

    uart_rx #(.N(8)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.data_re_i = re_main | re_tick;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick every 4 clks; optionally fires a read strobe on the tick that samples the stop bit.
    initial begin
        bus.tick_i = 1'b0;
        re_tick    = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.tick_i = 1'b1;
            if (arm_re && u_dut.state_q == ST_STOP && u_dut.cnt_q == OSR_LAST) begin
                re_tick  = 1'b1;
                arm_re   = 1'b0;
                re_fired = 1'b1;
            end
            @(negedge clk);
            bus.tick_i = 1'b0;
            re_tick    = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.frame_err_o) ferr_cnt++;
        if (bus.overrun_o)   ovr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx_i = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic mdl_frame(input logic [7:0] w, input logic stop_ok, input logic rd_same);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (!mdl_valid || rd_same) begin
            mdl_data  = w;
            mdl_valid = 1'b1;
        end else begin
            exp_ovr++;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".data"},  32'(bus.data_o), 32'(mdl_data));
        check_eq({tag, ".valid"}, 32'(bus.data_valid_o), 32'(mdl_valid));
        check_eq({tag, ".busy"},  32'(bus.busy_o), 32'd0);
        check_eq({tag, ".ferr"},  32'(ferr_cnt), 32'(exp_ferr));
        check_eq({tag, ".ovr"},   32'(ovr_cnt), 32'(exp_ovr));
    endtask

    task automatic do_read(input string tag);
        re_main = 1'b1;
        @(negedge clk);
        re_main   = 1'b0;
        mdl_valid = 1'b0;
        check_eq({tag, ".rd_valid"}, 32'(bus.data_valid_o), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        ferr_cnt = 0; ovr_cnt = 0; exp_ferr = 0; exp_ovr = 0;
        mdl_data = 8'h00; mdl_valid = 1'b0;
        re_main = 1'b0; arm_re = 1'b0; re_fired = 1'b0;
        bus.rx_i = 1'b1;
        bus.rx_en_i = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_state("reset");
        repeat (10) @(negedge clk);

        send_frame(8'hA5, 1'b1);
        mdl_frame(8'hA5, 1'b1, 1'b0);
        check_state("a5");
        do_read("a5");

        // Start glitch: 3 ticks low, rejected at mid start bit.
        bus.rx_i = 1'b0;
        repeat (12) @(negedge clk);
        bus.rx_i = 1'b1;
        check_eq("glitch.busy_mid", 32'(bus.busy_o), 32'd1);
        repeat (BIT_CLKS) @(negedge clk);
        check_state("glitch");

        send_frame(8'h3C, 1'b0);
        mdl_frame(8'h3C, 1'b0, 1'b0);
        check_state("ferr");

        send_frame(8'h11, 1'b1);
        mdl_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        mdl_frame(8'h22, 1'b1, 1'b0);
        check_state("overrun");

        re_fired = 1'b0;
        arm_re   = 1'b1;
        send_frame(8'h22, 1'b1);
        arm_re   = 1'b0;
        check_eq("simul.fired", 32'(re_fired), 32'd1);
        mdl_frame(8'h22, 1'b1, 1'b1);
        check_state("simul");
        do_read("simul");

        // Reset pulse during bit 4 of 0xFF; remaining bits are high so no new edge follows.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (BIT_CLKS * 5 + 32) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                mdl_data  = 8'h00;
                mdl_valid = 1'b0;
                check_eq("rst.data",  32'(bus.data_o), 32'd0);
                check_eq("rst.valid", 32'(bus.data_valid_o), 32'd0);
                check_eq("rst.busy",  32'(bus.busy_o), 32'd0);
            end
        join
        check_state("rst_after");
        send_frame(8'h5A, 1'b1);
        mdl_frame(8'h5A, 1'b1, 1'b0);
        check_state("5a");
        do_read("5a");

        bus.rx_en_i = 1'b0;
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                check_eq("dis.busy_mid", 32'(bus.busy_o), 32'd0);
            end
        join
        check_state("disabled");
        bus.rx_en_i = 1'b1;

        for (int k = 0; k < 8; k++) begin
            logic [7:0] w;
            logic       stop_ok;
            logic       rd;
            logic       drop_en;
            w       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            rd      = 1'($urandom_range(0, 1));
            drop_en = 1'($urandom_range(0, 1));
            fork
                send_frame(w, stop_ok);
                begin
                    if (drop_en) begin
                        repeat (200) @(negedge clk);
                        bus.rx_en_i = 1'b0;
                        repeat (200) @(negedge clk);
                        bus.rx_en_i = 1'b1;
                    end
                end
            join
            mdl_frame(w, stop_ok, 1'b0);
            check_state($sformatf("rnd%0d", k));
            if (rd) do_read($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
